// File: rtl/aes_pkg.sv
// Shared widths and controller state encoding for the AES-256 decryption
// pipeline and its issue controller.
package aes_pkg;

  localparam int aes_block_width_gp     = 128;
  localparam int aes_rounds_gp          = 14;
  localparam int aes_key_chain_width_gp = 1920;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } aes_ctrl_state_e;

endpackage

// File: rtl/aes_rr_arb.sv
// Round-robin grant over reqs_p requesters; the pointer moves past the
// winner only when the grant turns into a transfer.
module aes_rr_arb
  #(parameter  int reqs_p  = 2,
    localparam int id_w_lp = (reqs_p > 1) ? $clog2(reqs_p) : 1)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [reqs_p-1:0]  v_i,
   output logic [reqs_p-1:0]  grant_o,
   output logic [id_w_lp-1:0] grant_id_o,
   output logic               transfer_o);

  logic [id_w_lp-1:0] ptr_r;
  logic [id_w_lp-1:0] idx;
  logic               found;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    idx        = '0;
    found      = 1'b0;
    for (int i = 0; i < reqs_p; i++) begin
      idx = id_w_lp'((int'(ptr_r) + i) % reqs_p);
      if (!found && v_i[idx]) begin
        found      = 1'b1;
        grant_id_o = idx;
      end
    end
    transfer_o = en_i & found;
    if (transfer_o) grant_o[grant_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      ptr_r <= '0;
    else if (transfer_o)
      ptr_r <= (grant_id_o == id_w_lp'(reqs_p - 1)) ? '0 : grant_id_o + 1'b1;
  end

endmodule

// File: rtl/aes_dec_pipe_ctrl.sv
// Issue controller for the non-stallable AES-256 decryption datapath: arbitration,
// in-flight tracking, credit-bounded output buffering and drained key swaps.
module aes_dec_pipe_ctrl
  import aes_pkg::*;
  #(parameter  int lat_p      = 14,
    parameter  int fifo_els_p = 16,
    parameter  int reqs_p     = 2,
    localparam int id_w_lp    = (reqs_p > 1) ? $clog2(reqs_p) : 1)
  (input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [reqs_p-1:0]                    v_i,
   input  logic [aes_block_width_gp*reqs_p-1:0] ciphertext_i,
   output logic [reqs_p-1:0]                    ready_o,
   input  logic                                 key_v_i,
   input  logic [aes_key_chain_width_gp-1:0]    key_chain_i,
   output logic                                 key_ready_o,
   output logic [aes_block_width_gp-1:0]        dp_ciphertext_o,
   output logic [aes_key_chain_width_gp-1:0]    dp_key_chain_o,
   input  logic [aes_block_width_gp-1:0]        dp_plaintext_i,
   output logic                                 v_o,
   output logic [aes_block_width_gp-1:0]        plaintext_o,
   output logic [id_w_lp-1:0]                   id_o,
   input  logic                                 yumi_i,
   output logic                                 busy_o);

  localparam int cred_w_lp = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

  aes_ctrl_state_e state_r, state_n;

  logic                              issue_en, key_load, transfer, drained;
  logic [id_w_lp-1:0]                grant_id;
  logic [aes_block_width_gp-1:0]     ct_sel, ct_hold_r;
  logic [aes_key_chain_width_gp-1:0] key_chain_r;
  logic [cred_w_lp-1:0]              credits_r;
  logic [lat_p-1:0]                  sr_v_r;
  logic [id_w_lp-1:0]                sr_id_r [lat_p];

  logic                              enq, full;
  logic [ptr_w_lp-1:0]               wr_ptr_r, rd_ptr_r;
  logic [cred_w_lp-1:0]              count_r;
  logic [aes_block_width_gp-1:0]     fifo_data_r [fifo_els_p];
  logic [id_w_lp-1:0]                fifo_id_r   [fifo_els_p];

  assign drained = ~|sr_v_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= NOKEY;
    else         state_r <= state_n;
  end

  // A pending key always wins over issue, so RUN never grants while key_v_i is up.
  always_comb begin
    state_n  = state_r;
    issue_en = 1'b0;
    key_load = 1'b0;
    if (!reset_i) begin
      unique case (state_r)
        NOKEY: if (key_v_i) begin
          key_load = 1'b1;
          state_n  = RUN;
        end
        RUN: begin
          if (key_v_i) state_n  = DRAIN;
          else         issue_en = (credits_r != '0);
        end
        DRAIN: if (drained) begin
          key_load = key_v_i;
          state_n  = RUN;
        end
        default: state_n = NOKEY;
      endcase
    end
  end

  aes_rr_arb #(.reqs_p(reqs_p)) arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (issue_en),
    .v_i        (v_i),
    .grant_o    (ready_o),
    .grant_id_o (grant_id),
    .transfer_o (transfer)
  );

  assign ct_sel          = ciphertext_i[grant_id*aes_block_width_gp +: aes_block_width_gp];
  assign dp_ciphertext_o = transfer ? ct_sel : ct_hold_r;
  assign key_ready_o     = key_load;
  assign dp_key_chain_o  = key_chain_r;

  // NOTE: only control state is reset; data payloads (held ciphertext, tag and
  // FIFO storage) are qualified by valid bits and need no reset.
  always_ff @(posedge clk_i) begin
    if (transfer) ct_hold_r <= ct_sel;
    sr_id_r[0] <= grant_id;
    for (int i = 1; i < lat_p; i++) sr_id_r[i] <= sr_id_r[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_chain_r <= '0;
      sr_v_r      <= '0;
      credits_r   <= cred_w_lp'(fifo_els_p);
    end else begin
      if (key_load) key_chain_r <= key_chain_i;
      sr_v_r <= {sr_v_r[lat_p-2:0], transfer};
      unique case ({transfer, yumi_i})
        2'b10:   credits_r <= credits_r - 1'b1;
        2'b01:   credits_r <= credits_r + 1'b1;
        default: credits_r <= credits_r;
      endcase
    end
  end

  // First-word-fall-through output buffer; credits keep it from ever overflowing.
  assign enq  = sr_v_r[lat_p-1];
  assign full = (count_r == cred_w_lp'(fifo_els_p));

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_data_r[wr_ptr_r] <= dp_plaintext_i;
      fifo_id_r[wr_ptr_r]   <= sr_id_r[lat_p-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq)
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      if (yumi_i)
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      unique case ({enq, yumi_i})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq && full));
      assert (!(yumi_i && !v_o));
    end
  end

  assign v_o         = (count_r != '0);
  assign plaintext_o = fifo_data_r[rd_ptr_r];
  assign id_o        = fifo_id_r[rd_ptr_r];
  assign busy_o      = (|sr_v_r) | v_o;

endmodule
